pattern_check_seq: RTL and testbench

Parametrised self-checking stimulus sequencer for pipelined datapath blocks. On a `start` pulse it drives `NUM_TXN` data words in one of four pattern modes and tracks the expected value of each word through a `LATENCY`-deep delay line. It compares the device output against that expected value on the right cycle and reports a saturating error count, the index of the first mismatch, and pass/done status. It sits beside a device under test in block-level benches and in on-chip BIST wrappers.

---
 rtl/pattern_check_seq_pkg.sv | 30 +++
 rtl/pattern_check_seq_if.sv | 23 ++
 rtl/pattern_check_seq_pattern_gen.sv | 60 ++++++
 rtl/pattern_check_seq.sv | 141 ++++++++++++++
 tb/tb_pattern_check_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_check_seq_pkg.sv
// Shared types and constants for the pattern check sequencer.
// Pattern modes, FSM states and scoreboard sentinels.
package pchk_pkg;

  typedef enum logic [1:0] {
    FIXED,
    INCR,
    LFSR,
    ALT
  } pchk_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    REPORT
  } pchk_state_e;

  localparam logic [15:0] ERR_SAT    = 16'hFFFF;
  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

  // Galois step on a zero-extended state; callers truncate to WIDTH.
  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s,
    input logic [31:0] poly
  );
    return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
  endfunction

endpackage

// File: rtl/pattern_check_seq_if.sv
// Stimulus/response bus between the sequencer and the device.
// master = sequencer side, slave = device side.
interface pattern_check_seq_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] dut_din;
  logic             dut_vld;
  logic [WIDTH-1:0] dut_dout;

  modport master (
    output dut_din,
    output dut_vld,
    input  dut_dout
  );

  modport slave (
    input  dut_din,
    input  dut_vld,
    output dut_dout
  );

endinterface

// File: rtl/pattern_check_seq_pattern_gen.sv
// Pattern generator: holds the latched mode and current word.
// Loads word 0 on i_load, advances one word on i_step.
module pchk_pattern_gen
  import pchk_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter logic [31:0] SEED  = 32'hAA,
  parameter logic [31:0] POLY  = 32'hB8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  pchk_mode_e       i_mode,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_val
);

  localparam logic [WIDTH-1:0] P_SEED = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] P_POLY = WIDTH'(POLY);
  // An all-zero LFSR would lock up, so it starts from 1.
  localparam logic [WIDTH-1:0] P_LFSR0 =
    (P_SEED == '0) ? WIDTH'(1) : P_SEED;

  pchk_mode_e       r_mode;
  logic [WIDTH-1:0] r_val;
  logic [WIDTH-1:0] w_init;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_init = P_SEED;
    if (i_mode == LFSR) w_init = P_LFSR0;
  end

  always_comb begin
    w_next = r_val;
    unique case (r_mode)
      FIXED: w_next = r_val;
      INCR:  w_next = r_val + WIDTH'(1);
      LFSR:  w_next = WIDTH'(lfsr_next(
               32'(r_val), 32'(P_POLY)));
      ALT:   w_next = ~r_val;
      default: w_next = r_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= FIXED;
      r_val  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_val  <= w_init;
    end else if (i_step) begin
      r_val  <= w_next;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/pattern_check_seq.sv
// Self-checking stimulus sequencer: FSM, expected-value delay
// line and saturating scoreboard around pchk_pattern_gen.
module pattern_check_seq
  import pchk_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          LATENCY = 1,
  parameter int          NUM_TXN = 16,
  parameter logic [31:0] SEED    = 32'hAA,
  parameter logic [31:0] POLY    = 32'hB8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  pattern_check_seq_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [15:0]         first_err_idx
);

  localparam logic [15:0] LAST_K = 16'(NUM_TXN - 1);
  localparam logic [3:0]  LAST_D = 4'(LATENCY - 1);

  pchk_state_e r_state;
  pchk_state_e w_next;
  logic [15:0] r_k;
  logic [3:0]  r_dcnt;

  logic             r_dl_vld [LATENCY];
  logic [WIDTH-1:0] r_dl_exp [LATENCY];
  logic [15:0]      r_dl_idx [LATENCY];

  logic [15:0] r_err;
  logic [15:0] r_first;
  logic        r_pass;

  logic             w_accept;
  logic             w_drive;
  logic             w_step;
  logic [WIDTH-1:0] w_val;
  logic             w_mis;
  logic [15:0]      w_err_nxt;

  assign w_accept = (r_state == IDLE) && start;
  assign w_drive  = (r_state == DRIVE);
  // Hold the last word on the bus once the run is fully driven.
  assign w_step   = w_drive && (r_k != LAST_K);

  pchk_pattern_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED),
    .POLY  (POLY)
  ) u_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_mode (pchk_mode_e'(mode)),
    .i_step (w_step),
    .o_val  (w_val)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = DRIVE;
      DRIVE:  if (r_k == LAST_K) w_next = DRAIN;
      DRAIN:  if (r_dcnt == LAST_D) w_next = REPORT;
      REPORT: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_k <= '0;
      else if (w_step) r_k <= r_k + 16'd1;
      if (w_drive) r_dcnt <= '0;
      else if (r_state == DRAIN) r_dcnt <= r_dcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_exp[i] <= '0;
        r_dl_idx[i] <= '0;
      end
    end else begin
      r_dl_vld[0] <= w_drive;
      r_dl_exp[0] <= w_val;
      r_dl_idx[0] <= r_k;
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
        r_dl_idx[i] <= r_dl_idx[i-1];
      end
    end
  end

  assign w_mis = r_dl_vld[LATENCY-1] &&
                 (bus.dut_dout != r_dl_exp[LATENCY-1]);
  assign w_err_nxt = (w_mis && (r_err != ERR_SAT))
                   ? r_err + 16'd1 : r_err;

  // pass uses w_err_nxt: the last compare shares the REPORT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= '0;
      r_first <= NO_ERR_IDX;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_err   <= '0;
      r_first <= NO_ERR_IDX;
      r_pass  <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_mis && (r_first == NO_ERR_IDX))
        r_first <= r_dl_idx[LATENCY-1];
      if ((r_state == DRAIN) && (w_next == REPORT))
        r_pass <= (w_err_nxt == 16'd0);
    end
  end

  assign bus.dut_din   = w_val;
  assign bus.dut_vld   = w_drive;
  assign busy          = (r_state != IDLE);
  assign done          = (r_state == REPORT);
  assign pass          = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_pattern_check_seq.sv
// Bench for pattern_check_seq: six configurations, each with a
// behavioural device that can inject faults or be stuck at 0.
module tb_pattern_check_seq;

  localparam int NI = 6;

  function automatic int lat_f(int g);
    case (g)
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int num_f(int g);
    case (g)
      0: return 4;
      1, 2: return 5;
      3: return 4;
      4: return 3;
      default: return 65535;
    endcase
  endfunction

  function automatic logic [7:0] seed_f(int g);
    case (g)
      3: return 8'h00;
      4: return 8'hFE;
      5: return 8'hFF;
      default: return 8'hAA;
    endcase
  endfunction

  function automatic int dep_f(int g);
    case (g)
      1, 2: return 3;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]       st;
  logic [NI-1:0][1:0]  md;
  logic [NI-1:0]       busy;
  logic [NI-1:0]       done;
  logic [NI-1:0]       pass;
  logic [NI-1:0][15:0] errc;
  logic [NI-1:0][15:0] fidx;
  logic [NI-1:0][7:0]  din;
  logic [NI-1:0]       vld;

  int         f_idx [NI];
  logic [7:0] f_val [NI];
  logic       stuck [NI];
  logic [7:0] prev  [NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int D = dep_f(g);

    pattern_check_seq_if #(.WIDTH(8)) bus ();

    pattern_check_seq #(
      .WIDTH   (8),
      .LATENCY (lat_f(g)),
      .NUM_TXN (num_f(g)),
      .SEED    (32'(seed_f(g))),
      .POLY    (32'hB8)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (st[g]),
      .mode          (md[g]),
      .bus           (bus),
      .busy          (busy[g]),
      .done          (done[g]),
      .pass          (pass[g]),
      .err_count     (errc[g]),
      .first_err_idx (fidx[g])
    );

    logic [7:0] pd [3];
    logic       pv [3];
    int         pi [3];
    int         cnt;

    always @(posedge clk) begin
      if (st[g] && !busy[g]) cnt <= 0;
      else if (bus.dut_vld) cnt <= cnt + 1;
      pd[0] <= bus.dut_din;
      pv[0] <= bus.dut_vld;
      pi[0] <= cnt;
      for (int j = 1; j < 3; j++) begin
        pd[j] <= pd[j-1];
        pv[j] <= pv[j-1];
        pi[j] <= pi[j-1];
      end
    end

    assign bus.dut_dout =
      stuck[g] ? 8'h00 :
      (pv[D-1] && pi[D-1] == f_idx[g]) ? f_val[g] :
      pd[D-1];
    assign din[g] = bus.dut_din;
    assign vld[g] = bus.dut_vld;
  end

  function automatic logic [7:0] pat(int g, int m, int k);
    logic [7:0] s;
    s = seed_f(g);
    case (m)
      0: return s;
      1: return s + 8'(k);
      3: return (k % 2 == 1) ? ~s : s;
      default: begin
        if (s == 8'h00) s = 8'h01;
        for (int i = 0; i < k; i++)
          s = s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
        return s;
      end
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run(int g, int m, int fi, logic [7:0] fv,
                     bit poke, string nm);
    int n, l, dd, j, e_err, e_first, dcyc, dn;
    logic [7:0] recv, ex;
    n = num_f(g);
    l = lat_f(g);
    dd = dep_f(g);
    e_err = 0;
    e_first = 65535;
    dcyc = -1;
    dn = 0;
    for (int k = 0; k < n; k++) begin
      j = k + l - dd;
      ex = pat(g, m, k);
      if (stuck[g]) recv = 8'h00;
      else if (j < 0) recv = prev[g];
      else if (j == fi) recv = fv;
      else if (m == 2) recv = pat(g, m, j);
      else recv = pat(g, m, j);
      if (recv !== ex) begin
        if (e_err < 65535) e_err++;
        if (e_first == 65535) e_first = k;
      end
    end
    f_idx[g] = fi;
    f_val[g] = fv;
    @(negedge clk);
    st[g] = 1'b1;
    md[g] = 2'(m);
    @(negedge clk);
    st[g] = 1'b0;
    for (int c = 0; c < n + l + 3; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) chk({nm, ":busy"}, 32'(busy[g]), 1);
      if (c < n && c < 8) begin
        chk({nm, ":vld"}, 32'(vld[g]), 1);
        chk($sformatf("%s:din%0d", nm, c),
            32'(din[g]), 32'(pat(g, m, c)));
      end
      if (poke && c == 1) begin
        st[g] = 1'b1;
        md[g] = ~2'(m);
      end
      if (poke && c == 2) st[g] = 1'b0;
      if (done[g]) begin
        dn++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == n + l) begin
        chk({nm, ":err"}, 32'(errc[g]), 32'(e_err));
        chk({nm, ":first"}, 32'(fidx[g]), 32'(e_first));
        chk({nm, ":pass"}, 32'(pass[g]),
            32'(e_err == 0));
      end
    end
    chk({nm, ":done_cyc"}, 32'(dcyc), 32'(n + l));
    chk({nm, ":done_cnt"}, 32'(dn), 1);
    chk({nm, ":idle"}, 32'(busy[g]), 0);
    chk({nm, ":pass_hold"}, 32'(pass[g]),
        32'(e_err == 0));
    prev[g] = pat(g, m, n - 1);
  endtask

  initial begin
    int g, m, fi;
    rst_n = 1'b0;
    st = '0;
    md = '0;
    for (int i = 0; i < NI; i++) begin
      f_idx[i] = -1;
      f_val[i] = 8'h00;
      stuck[i] = (i == 5);
      prev[i]  = 8'h00;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d:busy", i), 32'(busy[i]), 0);
      chk($sformatf("rst%0d:done", i), 32'(done[i]), 0);
      chk($sformatf("rst%0d:pass", i), 32'(pass[i]), 0);
      chk($sformatf("rst%0d:err", i), 32'(errc[i]), 0);
      chk($sformatf("rst%0d:fidx", i), 32'(fidx[i]),
          32'hFFFF);
      chk($sformatf("rst%0d:vld", i), 32'(vld[i]), 0);
      chk($sformatf("rst%0d:din", i), 32'(din[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 1, -1, 8'h00, 1'b0, "incr_ok");
    run(0, 1, 2, 8'h00, 1'b0, "incr_err2");

    // Abort a run at word 2 with an asynchronous reset.
    st[0] = 1'b1;
    md[0] = 2'd1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort:pre_din", 32'(din[0]), 32'(pat(0, 1, 2)));
    rst_n = 1'b0;
    #1;
    chk("abort:busy", 32'(busy[0]), 0);
    chk("abort:vld", 32'(vld[0]), 0);
    chk("abort:din", 32'(din[0]), 0);
    chk("abort:done", 32'(done[0]), 0);
    chk("abort:fidx", 32'(fidx[0]), 32'hFFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort:no_done", 32'(done[0]), 0);
    end
    for (int i = 0; i < NI; i++) prev[i] = 8'h00;

    run(0, 1, -1, 8'h00, 1'b1, "fresh_poke");

    for (int it = 0; it < 12; it++) begin
      g = $urandom_range(0, 1);
      m = $urandom_range(0, 3);
      fi = ($urandom_range(0, 1) == 0) ? -1 :
           $urandom_range(0, num_f(g) - 1);
      run(g, m, fi, 8'($urandom), 1'($urandom),
          $sformatf("rnd%0d", it));
    end

    run(1, 3, -1, 8'h00, 1'b0, "alt_l3");
    run(2, 3, -1, 8'h00, 1'b0, "alt_l2_a");
    run(2, 3, -1, 8'h00, 1'b0, "alt_l2_b");
    run(3, 2, -1, 8'h00, 1'b0, "lfsr_s0");
    run(4, 1, -1, 8'h00, 1'b0, "incr_wrap");
    run(5, 0, -1, 8'h00, 1'b0, "stuck_sat");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
